pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
- Sequences the program counter and the instruction-memory fetch handshake for the MonoCPU front end.
- Owns the PC register; chooses the next PC from three sources: sequential +4, redirect from the branch/jump unit, or the trap vector.
- Issues one fetch request at a time to imem over a req/gnt handshake, honouring stall, halt and start controls.
- Provides a sticky timeout when imem never grants.

Parameters:
- XLEN, 32, address/PC width.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned redirect (MISALIGN_TRAP_EN only).
- TIMEOUT_CYC, 16, cycles in WAIT without grant before timeout; must be ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; leaves IDLE or HALTED.
- halt  in  1  level; stop fetching at the next ISSUE decision.
- stall  in  1  level; downstream not ready, do not launch a new fetch.
- redirect_valid  in  1  redirect request this cycle.
- redirect_addr  in  XLEN  redirect target.
- imem_req  out  1  fetch request (registered).
- imem_addr  out  XLEN  fetch address; equals pc_out while imem_req=1.
- imem_gnt  in  1  imem accepts request this cycle.
- pc_out  out  XLEN  current PC.
- instr_valid  out  1  one-cycle pulse the cycle after a grant.
- busy  out  1  high in ISSUE or WAIT.
- timeout  out  1  sticky; cleared only by reset.
- trap  out  1  one-cycle pulse on misaligned redirect (0 without feature).

Behaviour:
- Reset (rst_n=0, immediate, asynchronous): state=IDLE, pc_out=RESET_VECTOR, imem_req=0, instr_valid=0, busy=0, timeout=0, trap=0, pending redirect cleared. Reset mid-WAIT drops imem_req immediately.
- States:
  - IDLE: outputs quiet; start=1 → ISSUE.
  - ISSUE: imem_req=0. If halt=1 → HALTED. Else if stall=0 → WAIT with imem_req=1 and imem_addr=pc_out registered. Else stay.
  - WAIT: imem_req and imem_addr held stable until grant. imem_req&imem_gnt → ISSUE, pc_out←next PC, instr_valid=1 next cycle.
  - HALTED: imem_req=0; start=1 → ISSUE, resuming at pc_out. halt and stall are ignored in WAIT; a request is never withdrawn except on timeout or reset.
- Throughput: one fetch per 2 cycles minimum (ISSUE→WAIT with same-cycle grant).
- Next PC on grant, by priority:
  1. redirect_valid this cycle.
  2. Pending redirect register.
  3. pc_out+4, modulo 2^XLEN (32'hFFFF_FFFC → 0).
- Redirect in WAIT without grant: latched into the pending register; a later redirect overwrites it (latest wins); imem_addr does not change.
- Redirect in ISSUE, HALTED or IDLE: pc_out←redirect_addr next cycle; pending register cleared.
  - Redirect in ISSUE takes effect before the next WAIT launch only if it arrives at least one cycle before launch.
  - In the launch cycle, the redirect is loaded into pc_out and the fetch launches at the old pc_out value, then is discarded by the pending rule. Simplest rule: a redirect in the launch cycle suppresses the launch; stay in ISSUE one more cycle.
- Timeout: wait counter resets on entry to WAIT and increments each WAIT cycle without grant. On reaching TIMEOUT_CYC: timeout←1, imem_req←0, → HALTED. Grant in the same cycle as expiry wins; no timeout.
- busy=1 iff state ∈ {ISSUE, WAIT}. instr_valid is never asserted in two consecutive cycles.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: redirect_addr[1:0]≠0 loads TRAP_VECTOR instead of the target and pulses trap one cycle when applied to pc_out. Priority and pending rules are unchanged.
- Undefined: redirect_addr[1:0] forced to 2'b00; trap tied 0.

Test Plan:
- Reset release, start pulse, imem_gnt tied 1 → imem_addr sequence 0x0, 0x4, 0x8; instr_valid every 2nd cycle; pc_out=0xC after 3 grants.
- pc_out=0xFFFF_FFFC via redirect, fetch granted → pc_out wraps to 0x0000_0000.
- In WAIT at 0x10, gnt held 0 for 3 cycles, redirect 0x200 then 0x300, then gnt → imem_addr stays 0x10; next fetch address 0x300.
- stall=1 for 5 cycles in ISSUE → imem_req stays 0, pc_out unchanged; stall=0 → request issued the next cycle.
- gnt never asserted, TIMEOUT_CYC=16 → after 16 WAIT cycles imem_req=0, timeout=1, state HALTED; start resumes at same pc_out with timeout still 1.
- MISALIGN_TRAP_EN defined: redirect 0x102 → pc_out=0x100, trap pulse. Undefined: redirect 0x102 → pc_out=0x100, trap=0.

Source files
------------

// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if: control, redirect, imem handshake and status bundle for the fetch sequencer.
// master is the sequencer side; slave is the core/imem side.
interface pc_fetch_sequencer_if #(parameter int XLEN = 32);
  logic            start;
  logic            halt;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_addr;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic [XLEN-1:0] pc_out;
  logic            instr_valid;
  logic            busy;
  logic            timeout;
  logic            trap;
  modport master (
    input  start, halt, stall, redirect_valid, redirect_addr, imem_gnt,
    output imem_req, imem_addr, pc_out, instr_valid, busy, timeout, trap
  );
  modport slave (
    output start, halt, stall, redirect_valid, redirect_addr, imem_gnt,
    input  imem_req, imem_addr, pc_out, instr_valid, busy, timeout, trap
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC and runs a single-outstanding imem req/gnt fetch with sticky timeout.
// Define MISALIGN_TRAP_EN to send misaligned redirects to TRAP_VECTOR with a one-cycle trap pulse.
module pc_fetch_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int              TIMEOUT_CYC  = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  pc_fetch_sequencer_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALTED} state_t;
  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, addr_q, addr_d, pend_addr_q, pend_addr_d;
  logic            req_q, req_d, iv_q, iv_d, to_q, to_d, trap_q, trap_d;
  logic            pend_v_q, pend_v_d, pend_trap_q, pend_trap_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mis;
  logic [XLEN-1:0] eff;
`ifdef MISALIGN_TRAP_EN
  assign mis = |bus.redirect_addr[1:0];
`else
  assign mis = 1'b0;
`endif
  assign eff = mis ? TRAP_VECTOR : (bus.redirect_addr & ~XLEN'(3));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_VECTOR;
      addr_q      <= RESET_VECTOR;
      pend_addr_q <= '0;
      req_q       <= 1'b0;
      iv_q        <= 1'b0;
      to_q        <= 1'b0;
      trap_q      <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_trap_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      pend_addr_q <= pend_addr_d;
      req_q       <= req_d;
      iv_q        <= iv_d;
      to_q        <= to_d;
      trap_q      <= trap_d;
      pend_v_q    <= pend_v_d;
      pend_trap_q <= pend_trap_d;
      cnt_q       <= cnt_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    pend_addr_d = pend_addr_q;
    req_d       = req_q;
    iv_d        = 1'b0;
    to_d        = to_q;
    trap_d      = 1'b0;
    pend_v_d    = pend_v_q;
    pend_trap_d = pend_trap_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE, HALTED: begin
        if (bus.redirect_valid) begin
          pc_d     = eff;
          trap_d   = mis;
          pend_v_d = 1'b0;
        end
        if (bus.start) state_d = ISSUE;
      end
      ISSUE: begin
        if (bus.redirect_valid) begin
          pc_d     = eff;
          trap_d   = mis;
          pend_v_d = 1'b0;
        end
        // a redirect in the would-be launch cycle holds off the launch by one cycle
        if (bus.halt) state_d = HALTED;
        else if (!bus.redirect_valid && !bus.stall) begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = pc_q;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (bus.imem_gnt) begin
          state_d  = ISSUE;
          req_d    = 1'b0;
          iv_d     = 1'b1;
          pend_v_d = 1'b0;
          pc_d     = bus.redirect_valid ? eff : pend_v_q ? pend_addr_q : pc_q + XLEN'(4);
          trap_d   = bus.redirect_valid ? mis : pend_v_q & pend_trap_q;
        end else begin
          if (bus.redirect_valid) begin
            pend_v_d    = 1'b1;
            pend_addr_d = eff;
            pend_trap_d = mis;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            to_d    = 1'b1;
            req_d   = 1'b0;
            state_d = HALTED;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.pc_out      = pc_q;
  assign bus.instr_valid = iv_q;
  assign bus.busy        = (state_q == ISSUE) || (state_q == WAIT);
  assign bus.timeout     = to_q;
  assign bus.trap        = trap_q;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed test-plan scenarios plus random traffic against a cycle reference model.
module tb_pc_fetch_sequencer;
  localparam int          XLEN  = 32;
  localparam int          TO    = 16;
  localparam logic [31:0] TRAPV = 32'h100;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pc_fetch_sequencer_if #(.XLEN(XLEN)) bus();
  pc_fetch_sequencer #(.XLEN(XLEN), .TIMEOUT_CYC(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0;
  int bad = 0;
  typedef enum {M_IDLE, M_ISSUE, M_WAIT, M_HALT} mst_t;
  mst_t        m_st;
  logic [31:0] m_pc, m_addr, m_pend;
  logic        m_req, m_iv, m_to, m_trap, m_pv, m_pt;
  int          m_wait;
  logic [31:0] q[$];
  logic        exp_trap;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] tgt(input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return (a % 4 != 0) ? TRAPV : a;
`else
    return a - (a % 4);
`endif
  endfunction
  function automatic logic is_mis(input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return a % 4 != 0;
`else
    return 1'b0;
`endif
  endfunction
  task automatic model_reset();
    m_st = M_IDLE; m_pc = 0; m_addr = 0; m_pend = 0;
    m_req = 0; m_iv = 0; m_to = 0; m_trap = 0; m_pv = 0; m_pt = 0; m_wait = 0;
  endtask
  task automatic apply_redirect(input logic [31:0] ra);
    m_pc = tgt(ra); m_trap = is_mis(ra); m_pv = 0;
  endtask
  task automatic model_step(input logic s, h, st, rv, input logic [31:0] ra, input logic g);
    m_iv = 0; m_trap = 0;
    if (m_st == M_IDLE || m_st == M_HALT) begin
      if (rv) apply_redirect(ra);
      if (s) m_st = M_ISSUE;
    end else if (m_st == M_ISSUE) begin
      if (rv) apply_redirect(ra);
      if (h) m_st = M_HALT;
      else if (!rv && !st) begin
        m_st = M_WAIT; m_req = 1; m_addr = m_pc; m_wait = 0;
      end
    end else if (g) begin
      if (rv) begin m_pc = tgt(ra); m_trap = is_mis(ra); end
      else if (m_pv) begin m_pc = m_pend; m_trap = m_pt; end
      else m_pc = m_pc + 4;
      m_pv = 0; m_iv = 1; m_req = 0; m_st = M_ISSUE;
    end else begin
      if (rv) begin m_pv = 1; m_pend = tgt(ra); m_pt = is_mis(ra); end
      m_wait++;
      if (m_wait == TO) begin m_to = 1; m_req = 0; m_st = M_HALT; end
    end
  endtask
  task automatic check_all();
    chk("imem_req", 32'(bus.imem_req), 32'(m_req));
    if (m_req) chk("imem_addr", bus.imem_addr, m_addr);
    chk("pc_out", bus.pc_out, m_pc);
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_iv));
    chk("busy", 32'(bus.busy), 32'(m_st == M_ISSUE || m_st == M_WAIT));
    chk("timeout", 32'(bus.timeout), 32'(m_to));
    chk("trap", 32'(bus.trap), 32'(m_trap));
  endtask
  task automatic step(input logic s, h, st, rv, input logic [31:0] ra, input logic g);
    bus.start = s; bus.halt = h; bus.stall = st;
    bus.redirect_valid = rv; bus.redirect_addr = ra; bus.imem_gnt = g;
    @(posedge clk);
    model_step(s, h, st, rv, ra, g);
    #1;
    check_all();
  endtask
  task automatic tick(input logic g);
    step(0, 0, 0, 0, 32'h0, g);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    bus.start = 0; bus.halt = 0; bus.stall = 0;
    bus.redirect_valid = 0; bus.redirect_addr = 0; bus.imem_gnt = 0;
    do_reset();
    // sequential fetch with grant tied high
    step(1, 0, 0, 0, 32'h0, 1);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (bus.imem_req) q.push_back(bus.imem_addr);
    end
    chk("seq_pc", bus.pc_out, 32'hC);
    chk("seq_nfetch", 32'(q.size()), 32'd3);
    for (int i = 0; i < q.size(); i++) chk("seq_addr", q[i], 32'(4 * i));
    step(0, 1, 0, 0, 32'h0, 0);
    chk("halted_busy", 32'(bus.busy), 32'd0);
    // wrap past the top of the address space
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    step(1, 0, 0, 0, 32'h0, 0);
    tick(0);
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    tick(1);
    chk("wrap_pc", bus.pc_out, 32'h0);
    // latest pending redirect wins, in-flight address stays put
    step(0, 0, 0, 1, 32'h10, 0);
    tick(0);
    step(0, 0, 0, 1, 32'h200, 0);
    step(0, 0, 0, 1, 32'h300, 0);
    tick(0);
    chk("pend_hold_addr", bus.imem_addr, 32'h10);
    tick(1);
    chk("pend_pc", bus.pc_out, 32'h300);
    tick(0);
    chk("pend_next_addr", bus.imem_addr, 32'h300);
    tick(1);
    // stall in ISSUE
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 32'h0, 0);
      chk("stall_req", 32'(bus.imem_req), 32'd0);
    end
    chk("stall_pc", bus.pc_out, 32'h304);
    tick(0);
    chk("unstall_req", 32'(bus.imem_req), 32'd1);
    // timeout after TO ungranted WAIT cycles
    for (int i = 0; i < TO - 1; i++) tick(0);
    chk("pre_timeout", 32'(bus.timeout), 32'd0);
    tick(0);
    chk("timeout_set", 32'(bus.timeout), 32'd1);
    chk("timeout_req", 32'(bus.imem_req), 32'd0);
    step(1, 0, 0, 0, 32'h0, 0);
    tick(0);
    chk("resume_addr", bus.imem_addr, 32'h304);
    chk("timeout_sticky", 32'(bus.timeout), 32'd1);
    tick(1);
    // misaligned redirect
    do_reset();
    step(0, 0, 0, 1, 32'h102, 0);
    chk("mis_pc", bus.pc_out, 32'h100);
`ifdef MISALIGN_TRAP_EN
    exp_trap = 1'b1;
`else
    exp_trap = 1'b0;
`endif
    chk("mis_trap", 32'(bus.trap), 32'(exp_trap));
    tick(0);
    chk("mis_trap_clr", 32'(bus.trap), 32'd0);
    // random traffic
    begin
      int gp;
      gp = 50;
      for (int c = 0; c < 3000; c++) begin
        logic [31:0] ra;
        if (c % 64 == 0) gp = $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(20, 90));
        if ($urandom_range(0, 399) == 0) begin
          if (m_req) begin
            rst_n = 1'b0;
            #1;
            chk("async_rst_req", 32'(bus.imem_req), 32'd0);
          end
          do_reset();
        end
        ra = $urandom;
        if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
        if ($urandom_range(0, 9) == 0) ra = 32'hFFFF_FFFC;
        step($urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0, ra, int'($urandom_range(0, 99)) < gp);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
